// File: rtl/display_pkg.sv
// display_pkg: shared timing defaults, frame-size helper, controller state
// encoding and the packed layout of the vehicle status word shown on the panel.
package display_pkg;

    // Default panel timing (pixels for horizontal, lines for vertical).
    localparam int DEF_CLK_DIV    = 4;
    localparam int DEF_H_ACTIVE   = 480;
    localparam int DEF_H_FP       = 2;
    localparam int DEF_H_PULSE    = 41;
    localparam int DEF_H_BP       = 2;
    localparam int DEF_V_ACTIVE   = 272;
    localparam int DEF_V_FP       = 2;
    localparam int DEF_V_PULSE    = 10;
    localparam int DEF_V_BP       = 2;
    localparam int DEF_PWR_FRAMES = 3;

    // Width of the position counters and of disp_x / disp_y.
    localparam int CNT_W    = 10;
    localparam int STATUS_W = 29;

    // Total period of one axis: visible region, front porch, sync and back porch.
    function automatic int axis_total(input int active, input int fp,
                                      input int pulse, input int bp);
        return active + fp + pulse + bp;
    endfunction

    localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_PULSE, DEF_H_BP); // 525
    localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_PULSE, DEF_V_BP); // 286

    // Panel power sequencing states.
    typedef enum logic [1:0] {
        OFF     = 2'd0,
        PWR_ON  = 2'd1,
        RUN     = 2'd2,
        PWR_OFF = 2'd3
    } disp_state_e;

    // Status word as packed on status_in / status_q.
    typedef struct packed {
        logic [7:0] speed;           // [28:21]
        logic [7:0] car_battery;     // [20:13]
        logic [7:0] err_code;        // [12:5]
        logic       ready_to_drive;  // [4]
        logic [1:0] disp_battery;    // [3:2]
        logic [1:0] gps_status;      // [1:0]
    } status_t;

endpackage

// File: rtl/disp_clk_div.sv
// disp_clk_div: divides clk by CLK_DIV (even, >= 2) into the panel pixel clock
// DISP_CLK and a one-clk pixel strobe pix_en. DISP_CLK is held low while
// clk_en_i is low; pix_en keeps running so the timing counters never stop.
module disp_clk_div
    import display_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_en_i,
    output logic pix_en,
    output logic DISP_CLK
);

    localparam int            DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          pix_en_q, disp_clk_q;

    // Next divider phase: count 0..CLK_DIV-1 and wrap.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        div_cnt_d = div_cnt_q + 1'b1;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
        end
    end

    // Phase register; both outputs are decoded from the next phase so they are
    // flop outputs that always match the current div_cnt exactly.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            div_cnt_q  <= '0;
            pix_en_q   <= 1'b0;
            disp_clk_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            pix_en_q   <= (div_cnt_d == DIV_LAST);
            disp_clk_q <= clk_en_i && (div_cnt_d >= DIV_HALF);
        end
    end

    assign pix_en   = pix_en_q;
    assign DISP_CLK = disp_clk_q;

endmodule

// File: rtl/display_timing_ctrl.sv
// display_timing_ctrl: RGB panel timing generator with power sequencing.
// Free-running h/v counters produce sync, data enable and pixel position; a
// four-state controller walks the panel through PWR_ON and PWR_OFF blank
// frames and only ever changes state at a frame boundary (except an enable
// drop during PWR_ON, which aborts straight to PWR_OFF).
// Optional build macro DISP_STATUS_SHADOW_EN: when defined, status_q is a
// snapshot of status_in taken once per frame; otherwise it is a pass-through.
module display_timing_ctrl
    import display_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_PULSE    = DEF_H_PULSE,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_PULSE    = DEF_V_PULSE,
    parameter int V_BP       = DEF_V_BP,
    parameter int PWR_FRAMES = DEF_PWR_FRAMES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  status_t          status_in,
    output logic             DISP_CLK,
    output logic             pix_en,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic             DEN,
    output logic             DISP_EN,
    output logic [CNT_W-1:0] disp_x,
    output logic [CNT_W-1:0] disp_y,
    output logic             frame_start,
    output status_t          status_q
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_PULSE, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_PULSE, V_BP);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_PULSE);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_PULSE);

    localparam int            FW       = (PWR_FRAMES > 1) ? $clog2(PWR_FRAMES) : 1;
    localparam logic [FW-1:0] FRM_LAST = FW'(PWR_FRAMES - 1);

    disp_state_e      state_q;
    logic [FW-1:0]    frm_cnt_q;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             h_last, v_last;
    logic             frame_tick;
    logic             in_active, in_hsync, in_vsync;

    logic [CNT_W-1:0] disp_x_q, disp_y_q;
    logic             hsync_q, vsync_q, den_q, disp_en_q;
    logic             fs_pend_q, frame_start_q;

    // Pixel clock and pixel strobe; the panel clock only toggles while powered.
    disp_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk      (clk),
        .reset    (reset),
        .clk_en_i (state_q != OFF),
        .pix_en   (pix_en),
        .DISP_CLK (DISP_CLK)
    );

    // Next counter values and the frame-wrap event (last pixel of last line).
    always_comb begin
        h_last     = (h_cnt_q == H_LAST);
        v_last     = (v_cnt_q == V_LAST);
        frame_tick = pix_en && h_last && v_last;
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        if (pix_en) begin
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    // Position decode of the current counters, consumed by the output stage.
    always_comb begin
        in_active = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        in_hsync  = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
        in_vsync  = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
    end

    // Horizontal and vertical position counters; they run in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Power sequencer: transitions land on the counter wrap to (0,0), so a
    // frame is never cut short; only an enable drop in PWR_ON acts at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= OFF;
            frm_cnt_q <= '0;
        end else begin
            case (state_q)
                OFF: begin
                    if (frame_tick && enable) begin
                        state_q   <= PWR_ON;
                        frm_cnt_q <= '0;
                    end
                end
                PWR_ON: begin
                    if (!enable) begin
                        state_q   <= PWR_OFF;
                        frm_cnt_q <= '0;
                    end else if (frame_tick) begin
                        if (frm_cnt_q == FRM_LAST) begin
                            state_q   <= RUN;
                            frm_cnt_q <= '0;
                        end else begin
                            frm_cnt_q <= frm_cnt_q + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (frame_tick && !enable) begin
                        state_q   <= PWR_OFF;
                        frm_cnt_q <= '0;
                    end
                end
                PWR_OFF: begin
                    // enable is deliberately not looked at until OFF is reached.
                    if (frame_tick) begin
                        if (frm_cnt_q == FRM_LAST) begin
                            state_q   <= OFF;
                            frm_cnt_q <= '0;
                        end else begin
                            frm_cnt_q <= frm_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= OFF;
                    frm_cnt_q <= '0;
                end
            endcase
        end
    end

    // Output stage: every panel-facing signal is registered one clk behind the
    // counters and state, so position, syncs, DEN, DISP_EN and frame_start
    // all describe the same pixel. frame_start goes through fs_pend_q so it
    // lines up with disp_x/disp_y showing the origin.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_x_q      <= '0;
            disp_y_q      <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            den_q         <= 1'b0;
            disp_en_q     <= 1'b0;
            fs_pend_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            disp_x_q      <= in_active ? h_cnt_q : '0;
            disp_y_q      <= in_active ? v_cnt_q : '0;
            hsync_q       <= (state_q == OFF) || !in_hsync;
            vsync_q       <= (state_q == OFF) || !in_vsync;
            den_q         <= in_active && (state_q == RUN);
            disp_en_q     <= (state_q != OFF);
            fs_pend_q     <= frame_tick;
            frame_start_q <= fs_pend_q;
        end
    end

    assign disp_x      = disp_x_q;
    assign disp_y      = disp_y_q;
    assign HSYNC       = hsync_q;
    assign VSYNC       = vsync_q;
    assign DEN         = den_q;
    assign DISP_EN     = disp_en_q;
    assign frame_start = frame_start_q;

`ifdef DISP_STATUS_SHADOW_EN
    status_t status_snap_q;

    // Status snapshot taken on the frame_start clk so a frame never shows a
    // mix of old and new status fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            status_snap_q <= '0;
        end else if (fs_pend_q) begin
            status_snap_q <= status_in;
        end
    end

    assign status_q = status_snap_q;
`else
    assign status_q = status_in;
`endif

endmodule

// File: tb/tb_display_timing_ctrl.sv
// tb_display_timing_ctrl: directed bench on a shrunken panel so whole power
// sequences fit in a short run. Geometry used here:
//   CLK_DIV=4, H = 8+2+3+2 = 15 pixels, V = 4+1+2+1 = 8 lines, PWR_FRAMES=3
//   -> 4 clk/pixel, 60 clk/line, 480 clk/frame; HSYNC low h in [10,13),
//   VSYNC low v in [5,7). Time t counts clks after the last reset edge;
//   outputs seen at t describe the counters/state of clk t-1.
module tb_display_timing_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [28:0] status_in;
    logic        disp_clk, pix_en, hsync, vsync, den, disp_en, frame_start;
    logic [9:0]  disp_x, disp_y;
    logic [28:0] status_q;

    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    display_timing_ctrl #(
        .CLK_DIV    (4),
        .H_ACTIVE   (8),
        .H_FP       (2),
        .H_PULSE    (3),
        .H_BP       (2),
        .V_ACTIVE   (4),
        .V_FP       (1),
        .V_PULSE    (2),
        .V_BP       (1),
        .PWR_FRAMES (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .status_in   (status_in),
        .DISP_CLK    (disp_clk),
        .pix_en      (pix_en),
        .HSYNC       (hsync),
        .VSYNC       (vsync),
        .DEN         (den),
        .DISP_EN     (disp_en),
        .disp_x      (disp_x),
        .disp_y      (disp_y),
        .frame_start (frame_start),
        .status_q    (status_q)
    );

    always #5 clk = ~clk;

    // Clk index since the last clock edge that sampled reset high.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    typedef struct {
        int unsigned t;
        logic        en;
        logic        pix_en;
        logic        disp_clk;
        logic        hsync;
        logic        vsync;
        logic        den;
        logic        disp_en;
        logic        fs;
        logic [9:0]  x;
        logic [9:0]  y;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", name, act, exp, cyc);
        end
    endtask

    // Step on falling edges until the clk index reaches t (bounded).
    task automatic wait_to(input int unsigned t);
        int guard = 0;
        while (cyc < t && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != t) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_to: reached t=%0d, expected t=%0d", cyc, t);
        end
    endtask

    // Same as wait_to, counting falling-edge samples with DEN high.
    task automatic watch_den(input int unsigned t, output int hits);
        int guard = 0;
        hits = 0;
        while (cyc < t && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (den) hits++;
        end
    endtask

    task automatic add(input int unsigned t, input logic en, input logic pe, input logic dc,
                       input logic hs, input logic vs, input logic de, input logic pw,
                       input logic fs, input int x, input int y);
        vec_t v;
        v.t = t; v.en = en; v.pix_en = pe; v.disp_clk = dc; v.hsync = hs; v.vsync = vs;
        v.den = de; v.disp_en = pw; v.fs = fs; v.x = 10'(x); v.y = 10'(y);
        vecs.push_back(v);
    endtask

    initial begin
        int hits;

        //   t     en pe dc hs vs den pw fs  x  y
        add(   0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0); // reset values
        add(   3, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0); // first pixel strobe, OFF: no DISP_CLK
        add(   4, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        add(  41, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0); // h=10 but OFF holds HSYNC high
        add( 481, 1, 0, 0, 1, 1, 0, 1, 1, 0, 0); // first frame_start: DISP_EN rises
        add( 482, 1, 0, 1, 1, 1, 0, 1, 0, 0, 0); // DISP_CLK now running
        add( 521, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0); // h=10: HSYNC low, no DEN in PWR_ON
        add( 529, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0); // h=12: last sync pixel
        add( 533, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0); // h=13: sync released
        add( 781, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0); // v=5: VSYNC low
        add(1921, 1, 0, 0, 1, 1, 1, 1, 1, 0, 0); // DEN first high, 3 frames after DISP_EN
        add(1941, 1, 0, 0, 1, 1, 1, 1, 0, 5, 0); // x=5 in RUN
        add(1953, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0); // enable dropped; h=8 blanking
        add(2130, 0, 0, 1, 1, 1, 1, 1, 0, 7, 3); // frame finishes with DEN active
        add(2161, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0); // v=4 vertical blanking
        add(2401, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0); // PWR_OFF: DEN gated, panel still powered
        add(2441, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0); // syncs still produced in PWR_OFF
        add(2881, 1, 0, 0, 1, 1, 0, 1, 1, 0, 0); // enable=1 ignored in PWR_OFF
        add(3841, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0); // DISP_EN falls 3 frames after RUN exit
        add(3882, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0); // OFF: h=10 yet HSYNC high, DISP_CLK low
        add(4322, 1, 0, 1, 1, 1, 0, 1, 0, 0, 0); // next frame: back to PWR_ON

        reset     = 1'b1;
        enable    = 1'b1;
        status_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            enable = vecs[i].en;
            wait_to(vecs[i].t);
            check($sformatf("v%0d.pix_en", i),      32'(pix_en),      32'(vecs[i].pix_en));
            check($sformatf("v%0d.DISP_CLK", i),    32'(disp_clk),    32'(vecs[i].disp_clk));
            check($sformatf("v%0d.HSYNC", i),       32'(hsync),       32'(vecs[i].hsync));
            check($sformatf("v%0d.VSYNC", i),       32'(vsync),       32'(vecs[i].vsync));
            check($sformatf("v%0d.DEN", i),         32'(den),         32'(vecs[i].den));
            check($sformatf("v%0d.DISP_EN", i),     32'(disp_en),     32'(vecs[i].disp_en));
            check($sformatf("v%0d.frame_start", i), 32'(frame_start), 32'(vecs[i].fs));
            check($sformatf("v%0d.disp_x", i),      32'(disp_x),      32'(vecs[i].x));
            check($sformatf("v%0d.disp_y", i),      32'(disp_y),      32'(vecs[i].y));
        end

        // Abort during the second PWR_ON frame: immediate PWR_OFF with a fresh
        // frame count (ticks 5280, 5760, 6240), and DEN never asserts.
        wait_to(5000);
        check("abort.pre_DISP_EN", 32'(disp_en), 32'd1);
        check("abort.pre_DEN", 32'(den), 32'd0);
        enable = 1'b0;
        watch_den(6240, hits);
        check("abort.DISP_EN_held", 32'(disp_en), 32'd1);
        wait_to(6241);
        check("abort.DISP_EN_off", 32'(disp_en), 32'd0);
        check("abort.frame_start", 32'(frame_start), 32'd1);
        check("abort.den_hits", 32'(hits), 32'd0);

        // Power up again (PWR_ON at 6720, RUN at 8160), then reset mid-frame.
        enable = 1'b1;
        wait_to(8360);
        check("mid.DEN", 32'(den), 32'd1);
        check("mid.disp_x", 32'(disp_x), 32'd4);
        check("mid.disp_y", 32'(disp_y), 32'd3);
        status_in = 29'h0000ABC;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst.DISP_EN", 32'(disp_en), 32'd0);
        check("rst.DEN", 32'(den), 32'd0);
        check("rst.HSYNC", 32'(hsync), 32'd1);
        check("rst.VSYNC", 32'(vsync), 32'd1);
        check("rst.DISP_CLK", 32'(disp_clk), 32'd0);
        check("rst.pix_en", 32'(pix_en), 32'd0);
        check("rst.frame_start", 32'(frame_start), 32'd0);
        check("rst.disp_x", 32'(disp_x), 32'd0);
        check("rst.disp_y", 32'(disp_y), 32'd0);
`ifdef DISP_STATUS_SHADOW_EN
        check("rst.status_q", 32'(status_q), 32'h0);
`else
        check("rst.status_q", 32'(status_q), 32'h0000ABC);
`endif
        wait_to(2);
        check("restart.DISP_EN", 32'(disp_en), 32'd0);
        wait_to(3);
        check("restart.pix_en", 32'(pix_en), 32'd1);
`ifdef DISP_STATUS_SHADOW_EN
        wait_to(100);
        check("shadow.before_first", 32'(status_q), 32'h0);
`endif
        wait_to(481);
        check("restart.frame_start", 32'(frame_start), 32'd1);
        check("restart.DISP_EN_on", 32'(disp_en), 32'd1);
`ifdef DISP_STATUS_SHADOW_EN
        check("shadow.load", 32'(status_q), 32'h0000ABC);
`endif
        wait_to(600);
        status_in = 29'h1FFFFFF;
        wait_to(601);
`ifdef DISP_STATUS_SHADOW_EN
        check("shadow.hold_mid", 32'(status_q), 32'h0000ABC);
        wait_to(960);
        check("shadow.hold_end", 32'(status_q), 32'h0000ABC);
        wait_to(961);
        check("shadow.reload", 32'(status_q), 32'h1FFFFFF);
`else
        check("pass.status_q", 32'(status_q), 32'h1FFFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
